sync_fifo_param: RTL

Single-clock, parametrised FIFO that generalises the team's 128-bit CDC FIFO into a reusable buffer for the order/market-data pipeline. Inside one clock domain it provides:
- configurable width and depth;
- show-ahead (FWFT) or standard read mode;
- an exact fill level and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags and a synchronous flush.

It sits between feed-parsing stages and order-book/strategy logic wherever rate decoupling is needed without a clock crossing.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, helpers and elaboration-time parameter checks for the FIFO family.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Stops elaboration when the geometry or a threshold does not make sense.
`define FIFO_PARAM_CHECK(D, AW, AF, AE) \
  if ((D) < 4 || (D) != (1 << (AW)) || (AW) != fifo_pkg::clog2(D)) begin : g_chk_depth \
    $error("sync_fifo_param: DEPTH must be a power of two >= 4 equal to 2**ADDR_WIDTH"); \
  end \
  if ((AF) < 1 || (AF) > (D) || (AE) < 0 || (AE) >= (D)) begin : g_chk_thresh \
    $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range"); \
  end

package fifo_pkg;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int FIFO_WIDTH_DEFAULT = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction
endpackage

`endif

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH distributed storage: synchronous write, asynchronous read.
// Latency: written word readable the cycle after the write edge; no backpressure, caller gates wr_en.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with FWFT/standard read, exact level, almost flags, sticky errors, flush.
// Latency: 1 cycle write-to-visible; backpressure via wr_ready = !full, refused pushes raise overflow.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  `FIFO_PARAM_CHECK(DEPTH, ADDR_WIDTH, AF_THRESH, AE_THRESH)

  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_L    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L    = AE_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic [WIDTH-1:0]    mem_rd_data;
  logic                push, pop, ovf_evt, udf_evt;

  // Flush outranks both requests, so neither moves a pointer nor flags an error.
  assign push    = wr_en && !full  && !flush;
  assign pop     = rd_en && !empty && !flush;
  assign ovf_evt = wr_en && full   && !flush;
  assign udf_evt = rd_en && empty  && !flush;

  assign wr_ready = !full;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
    end
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Status is derived from next-state pointers so it never lags the pointer update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      full         <= (level_nxt == DEPTH_L);
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
      overflow     <= (overflow  && !clr_err) || ovf_evt;
      underflow    <= (underflow && !clr_err) || udf_evt;
    end
  end

  fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; zeroed while empty so reset shows rd_data = 0.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_rd_data;
  end else begin : g_std
    logic             vld_q;
    logic [WIDTH-1:0] dat_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= pop;
        if (pop) dat_q <= mem_rd_data;
      end
    end

    assign rd_valid = vld_q;
    assign rd_data  = dat_q;
  end

endmodule
